// File: rtl/ffdiv_serial.sv
// ffdiv_serial: bit-serial GF(2^WIDTH) divider, result = a * finv(b).
// The divisor is sent to an external inverse LUT (lut_in/lut_out) and the
// returned inverse is multiplied by a, one bit per cycle, MSB first, mod POLY.
// Optional feature macro: FFDIV_ZERO_SKIP_EN - when defined, an op whose
// dividend or looked-up inverse is zero bypasses the multiply loop.
module ffdiv_serial #(
  parameter int             WIDTH = 8,
  parameter logic [WIDTH:0] POLY  = 9'h11B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] lut_in,
  input  logic [31:0] lut_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] inv_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;
  logic [CW-1:0]    cnt;
  logic             dz_reg;
  logic             b_is_zero;
  logic             skip_mul;
  logic             unused_bits;

  // Operand bits above the field degree are ignored on every input bus.
  assign unused_bits = ^{a_in[31:WIDTH], b_in[31:WIDTH], lut_out[31:WIDTH]};

  // The LUT sees the divisor at all times; it is only sampled on accept.
  assign lut_in    = 32'(b_in[WIDTH-1:0]);
  assign b_is_zero = (b_in[WIDTH-1:0] == '0);

`ifdef FFDIV_ZERO_SKIP_EN
  // A zero dividend or zero inverse gives a zero product, so skip the loop.
  assign skip_mul = (a_in[WIDTH-1:0] == '0) || (lut_out[WIDTH-1:0] == '0);
`else
  assign skip_mul = 1'b0;
`endif

  // One shift-and-reduce step: double acc in the field, then add a if the
  // current inverse bit is set.
  always_comb begin
    acc_step = {acc[WIDTH-2:0], 1'b0};
    if (acc[WIDTH-1]) begin
      acc_step = acc_step ^ POLY[WIDTH-1:0];
    end
    if (inv_reg[cnt]) begin
      acc_step = acc_step ^ a_reg;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush beats everything, including a pending accept.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (b_is_zero || skip_mul) begin
              state_next = DONE;
            end else begin
              state_next = MUL;
            end
          end
        end
        MUL: begin
          if (cnt == '0) begin
            state_next = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: capture operands on accept, then iterate the multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      inv_reg <= '0;
      acc     <= '0;
      cnt     <= '0;
      dz_reg  <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a_in[WIDTH-1:0];
            inv_reg <= lut_out[WIDTH-1:0];
            acc     <= '0;
            cnt     <= CW'(WIDTH - 1);
            dz_reg  <= b_is_zero;
          end
        end
        MUL: begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs come straight from registered state; result/div_zero are zero
  // whenever no result is being offered.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = out_valid ? 32'(acc) : 32'd0;
  assign div_zero  = out_valid & dz_reg;

endmodule

// File: tb/tb_ffdiv_serial.sv
// tb_ffdiv_serial: directed self-checking bench for ffdiv_serial (WIDTH=8,
// POLY=0x11B) with an inverse LUT modelled as lut_out = 255 - lut_in.
module tb_ffdiv_serial;

`ifdef FFDIV_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 9;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [31:0] lut_in;
  logic [31:0] lut_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        div_zero;

  int num_compared   = 0;
  int num_mismatched = 0;

  ffdiv_serial #(.WIDTH(8), .POLY(9'h11B)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in),
    .lut_in(lut_in), .lut_out(lut_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Inverse LUT stand-in: upper bits deliberately non-zero to prove they are ignored.
  assign lut_out = {24'hA5A5A5, 8'hFF - lut_in[7:0]};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, ".result"}, result, 32'd0);
    checkOutput({tag, ".div_zero"}, 32'(div_zero), 32'd0);
  endtask

  // Present one operand pair for a single cycle (with junk upper bits).
  task automatic startOp(input string tag, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    a_in = ($urandom() & 32'hFFFF_FF00) | 32'(a);
    b_in = ($urandom() & 32'hFFFF_FF00) | 32'(b);
    in_valid = 1'b1;
    #1;
    checkOutput({tag, ".lut_in"}, lut_in, 32'(b));
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a_in = $urandom();
    b_in = $urandom();
  endtask

  // Full operation: accept, measure latency, check result, optionally stall
  // the consumer, then hand the result off. noisy keeps in_valid high with
  // junk operands while busy, which must be ignored.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] exp_res, input logic exp_dz,
                               input int exp_lat, input int hold, input bit noisy);
    int lat;
    startOp(tag, a, b);
    in_valid = noisy;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    checkOutput({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, ".result"}, result, 32'(exp_res));
    checkOutput({tag, ".div_zero"}, 32'(div_zero), 32'(exp_dz));
    checkOutput({tag, ".busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, ".held_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, ".held_result"}, result, 32'(exp_res));
      checkOutput({tag, ".held_dz"}, 32'(div_zero), 32'(exp_dz));
      checkOutput({tag, ".held_busy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, ".post_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, ".post_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int rises;
    #2;
    checkIdle("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic products and the reduction path.
    applyStimulus("t1_53_35", 8'h53, 8'h35, 8'h01, 1'b0, 9, 0, 1'b0);
    applyStimulus("t2_reduce", 8'h80, 8'hFD, 8'h1B, 1'b0, 9, 0, 1'b0);
    applyStimulus("t2_inv1", 8'h02, 8'hFE, 8'h02, 1'b0, 9, 0, 1'b0);
    applyStimulus("ff_x_1", 8'hFF, 8'hFE, 8'hFF, 1'b0, 9, 0, 1'b0);
    applyStimulus("02_x_02", 8'h02, 8'hFD, 8'h04, 1'b0, 9, 0, 1'b0);

    // Divide by zero short path.
    applyStimulus("t3_bzero", 8'h77, 8'h00, 8'h00, 1'b1, 1, 0, 1'b0);

    // Consumer stall with busy-time input noise.
    applyStimulus("t4_stall", 8'h53, 8'h35, 8'h01, 1'b0, 9, 5, 1'b1);

    // Zero dividend / zero inverse.
    applyStimulus("t6_azero", 8'h00, 8'h10, 8'h00, 1'b0, ZERO_LAT, 0, 1'b0);
    applyStimulus("t6_invzero", 8'h45, 8'hFF, 8'h00, 1'b0, ZERO_LAT, 0, 1'b0);

    // Flush on the fourth MUL cycle: result must never appear.
    startOp("t5_flush", 8'h53, 8'h35);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("t5_flush.in_ready", 32'(in_ready), 32'd1);
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    checkOutput("t5_flush.no_valid", 32'(rises), 32'd0);

    // Flush together with in_valid in IDLE: no capture.
    @(negedge clk);
    a_in = 32'h53;
    b_in = 32'h35;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    checkIdle("flush_idle");
    repeat (10) @(negedge clk);
    checkOutput("flush_idle.later_valid", 32'(out_valid), 32'd0);

    applyStimulus("t5_after", 8'h53, 8'h35, 8'h01, 1'b0, 9, 0, 1'b0);

    // Asynchronous reset mid-MUL.
    startOp("rst_mul", 8'h53, 8'h35);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkIdle("rst_mul");
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset while a nonzero result is being held.
    startOp("rst_done", 8'h80, 8'hFD);
    rises = 1;
    while (!out_valid && rises < 40) begin
      @(negedge clk);
      rises++;
    end
    checkOutput("rst_done.result", result, 32'h1B);
    rst = 1'b1;
    #1;
    checkIdle("rst_done");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("final", 8'h53, 8'h35, 8'h01, 1'b0, 9, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
